// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM lane controller and its array model.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } sram_state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;  // no error
  localparam logic [1:0] ERR_BUSY = 2'd1;  // command while busy, or w_en and r_en together
  localparam logic [1:0] ERR_BUF  = 2'd2;  // underfull load, or write with no valid buffer
  localparam logic [1:0] ERR_ADDR = 2'd3;  // addr >= ROWS

  // Counter/address width that stays at least one bit for degenerate sizes.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_array_model.sv
// Behavioural stand-in for the analog SRAM macro: synchronous write, registered read.
module sram_array_model
  import sram_pkg::*;
#(
  parameter  int ROWS = 16,
  parameter  int COLS = 8,
  localparam int AW   = addr_width(ROWS)
) (
  input  logic            clk,
  input  logic            we,
  input  logic            re,
  input  logic [AW-1:0]   addr,
  input  logic [COLS-1:0] wdata,
  output logic [COLS-1:0] rdata
);

  logic [COLS-1:0] mem [ROWS];

  // Row write on we, registered read of addr on re.
  // NOTE: storage arrays carry no reset; the real macro cannot clear itself and
  // a reset port here would turn the array into flops.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/sram_lane_ctrl.sv
// Multi-lane serial loader, write buffer and command sequencer for the SRAM macro.
module sram_lane_ctrl
  import sram_pkg::*;
#(
  parameter  int ROWS      = 16,
  parameter  int COLS      = 8,
  parameter  int LANES     = 2,
  parameter  int WRITE_LAT = 1,
  parameter  int READ_LAT  = 2,
  localparam int AW        = addr_width(ROWS)
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [LANES-1:0] serial_in,
  input  logic             shift,
  input  logic             load,
  input  logic             w_en,
  input  logic             r_en,
  input  logic [AW-1:0]    addr,
  output logic             busy,
  output logic             data_valid,
  output logic [COLS-1:0]  data_out,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int BEATS  = COLS / LANES;
  localparam int CW     = addr_width(BEATS + 1);
  localparam int MAXLAT = (WRITE_LAT > READ_LAT) ? WRITE_LAT : READ_LAT;
  localparam int LW     = addr_width(MAXLAT);
  localparam logic [AW:0] ROWS_W = ROWS[AW:0];

  logic [COLS-1:0]       sr, wbuf, lat_data, arr_rdata, sr_shifted;
  logic [COLS+LANES-1:0] sr_cat;
  logic [CW-1:0]         cnt;
  logic                  buf_valid, sr_full, addr_ok;
  logic [AW-1:0]         lat_addr, arr_addr;
  logic [LW-1:0]         lat_cnt;
  logic                  wr_last, rd_last, accept_wr, accept_rd, arr_we, arr_re;
  logic [1:0]            cmd_code, err_nxt;
  sram_state_t           state, state_nxt;

  assign sr_cat     = {sr, serial_in};
  assign sr_shifted = sr_cat[COLS-1:0];
  assign sr_full    = (cnt == CW'(BEATS));
  assign addr_ok    = ({1'b0, addr} < ROWS_W);
  assign wr_last    = (lat_cnt == LW'(WRITE_LAT - 1));
  assign rd_last    = (lat_cnt == LW'(READ_LAT - 1));
  assign busy       = (state == WRITE) || (state == READ);

  // Command qualification and error priority: busy/collision, then address, then buffer.
  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    cmd_code  = ERR_NONE;
    if ((w_en || r_en) && (state != IDLE || (w_en && r_en))) cmd_code = ERR_BUSY;
    else if ((w_en || r_en) && !addr_ok)                     cmd_code = ERR_ADDR;
    else if (w_en && !buf_valid)                             cmd_code = ERR_BUF;
    accept_wr = w_en && (cmd_code == ERR_NONE);
    accept_rd = r_en && (cmd_code == ERR_NONE);
    err_nxt   = cmd_code;
    if (cmd_code == ERR_NONE && load && !sr_full) err_nxt = ERR_BUF;
  end

  // Next-state logic and array strobes.
  always_comb begin
    state_nxt = state;
    arr_we    = 1'b0;
    arr_re    = accept_rd;
    arr_addr  = addr;
    unique case (state)
      IDLE: begin
        if (accept_wr)      state_nxt = WRITE;
        else if (accept_rd) state_nxt = READ;
      end
      WRITE: begin
        arr_addr = lat_addr;
        arr_we   = wr_last;
        if (wr_last) state_nxt = IDLE;
      end
      READ: begin
        if (rd_last) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and per-state latency counter, restarted on every transition.
  // NOTE: clocked state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state   <= IDLE;
      lat_cnt <= '0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= (state_nxt != state) ? '0 : lat_cnt + LW'(1);
    end
  end

  // Shift register and write buffer; load wins over shift in the same cycle.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sr        <= '0;
      cnt       <= '0;
      wbuf      <= '0;
      buf_valid <= 1'b0;
    end else if (load) begin
      if (sr_full) begin
        wbuf      <= sr;
        buf_valid <= 1'b1;
        cnt       <= '0;
      end
    end else if (shift) begin
      sr <= sr_shifted;
      if (!sr_full) cnt <= cnt + CW'(1);
    end
  end

  // Capture address and data of an accepted write so later loads cannot disturb it.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      lat_addr <= '0;
      lat_data <= '0;
    end else if (accept_wr) begin
      lat_addr <= addr;
      lat_data <= wbuf;
    end
  end

  // Registered outputs: read completion pulse, held read data and error pulse.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      data_valid <= 1'b0;
      data_out   <= '0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      data_valid <= (state == DONE);
      if (state == DONE) data_out <= arr_rdata;
      err        <= (err_nxt != ERR_NONE);
      err_code   <= err_nxt;
    end
  end

  sram_array_model #(.ROWS(ROWS), .COLS(COLS)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (arr_addr),
    .wdata (lat_data),
    .rdata (arr_rdata)
  );

endmodule
